// File: rtl/alu_iq_pkg.sv
// -----------------------------------------------------------------------------
// alu_iq_pkg
// Shared types and constants for the ALU issue queue.
//   DEPTH_MAX  : largest supported queue depth
//   SID_W_DEF  : scoreboard id / tag width used by the entry struct
//   iq_entry_t : one queue entry (op payload, operand ready bits, tags, values)
//   iq_wakeup  : applies a result broadcast to one entry
// Optional feature macro used by the queue: ALU_IQ_BYPASS_EN.
// -----------------------------------------------------------------------------
`ifndef SCOREBOARD_SIZE_WIDTH
`define SCOREBOARD_SIZE_WIDTH 4
`endif

package alu_iq_pkg;

  localparam int DEPTH_MAX = 8;
  localparam int SID_W_DEF = `SCOREBOARD_SIZE_WIDTH;

  typedef struct packed {
    logic [SID_W_DEF-1:0] sid;
    logic [2:0]           func3;
    logic                 auipc;
    logic [63:0]          pc;
    logic [31:0]          inst;
    logic [3:0]           func_code;
    logic                 rs1_rdy;
    logic [SID_W_DEF-1:0] rs1_tag;
    logic [63:0]          rs1_value;
    logic                 rs2_rdy;
    logic [SID_W_DEF-1:0] rs2_tag;
    logic [63:0]          rs2_value;
  } iq_entry_t;

  // A waiting operand whose tag matches the broadcast id becomes ready and
  // takes the broadcast value; operands already ready are left untouched.
  function automatic iq_entry_t iq_wakeup(input iq_entry_t            e,
                                          input logic                 wb_valid,
                                          input logic [SID_W_DEF-1:0] wb_sid,
                                          input logic [63:0]          wb_value);
    iq_entry_t r;
    r = e;
    if (wb_valid && !e.rs1_rdy && (e.rs1_tag == wb_sid)) begin
      r.rs1_rdy   = 1'b1;
      r.rs1_value = wb_value;
    end
    if (wb_valid && !e.rs2_rdy && (e.rs2_tag == wb_sid)) begin
      r.rs2_rdy   = 1'b1;
      r.rs2_value = wb_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// -----------------------------------------------------------------------------
// iq_oldest_select
// Lowest-index priority selector. Index 0 is the oldest queue entry, so the
// grant always goes to the oldest requester.
//   i_req       : per-entry ready request
//   o_grant     : one-hot grant (all zero when nothing requests)
//   o_any_ready : at least one request is set
// -----------------------------------------------------------------------------
module iq_oldest_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_grant,
  output logic         o_any_ready
);

  // Two's-complement trick: x & -x isolates the lowest set bit.
  assign o_grant     = i_req & (~i_req + N'(1));
  assign o_any_ready = |i_req;

endmodule

// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
// Collapsing issue queue in front of a single ALU. Entry 0 is the oldest;
// occupied entries are contiguous from 0. Each cycle the oldest entry with
// both operands ready (registered ready bits) is sent to the ALU and the
// entries above it shift down. Result broadcasts wake waiting operands,
// including the op being enqueued in the same cycle.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   flush_i                    : drop every entry at the next edge
//   enq_valid_i / enq_ready_o  : enqueue handshake
//   enq_*_i                    : op payload and operand state
//   wb_valid_i/wb_sid_i/wb_value_i : result wakeup broadcast
//   alu_*_o, rs*_value_o, func_code_o : issue port (no backpressure)
//   count_o                    : occupied entries
// Optional feature: define ALU_IQ_BYPASS_EN to let a ready op go straight to
// the ALU in its enqueue cycle when no queued entry is ready.
// -----------------------------------------------------------------------------
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SID_W = `SCOREBOARD_SIZE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [SID_W-1:0] enq_sid_i,
  input  logic [2:0]       enq_func3_i,
  input  logic             enq_auipc_i,
  input  logic [63:0]      enq_pc_i,
  input  logic [31:0]      enq_inst_i,
  input  logic [3:0]       enq_func_code_i,
  input  logic             enq_rs1_rdy_i,
  input  logic [SID_W-1:0] enq_rs1_tag_i,
  input  logic [63:0]      enq_rs1_value_i,
  input  logic             enq_rs2_rdy_i,
  input  logic [SID_W-1:0] enq_rs2_tag_i,
  input  logic [63:0]      enq_rs2_value_i,
  input  logic             wb_valid_i,
  input  logic [SID_W-1:0] wb_sid_i,
  input  logic [63:0]      wb_value_i,
  output logic             alu_valid_o,
  output logic [SID_W-1:0] alu_sid_o,
  output logic [2:0]       alu_func3_o,
  output logic             alu_auipc_o,
  output logic [63:0]      alu_pc_o,
  output logic [31:0]      alu_inst_o,
  output logic [63:0]      rs1_value_o,
  output logic [63:0]      rs2_value_o,
  output logic [3:0]       func_code_o,
  output logic [3:0]       count_o
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  iq_entry_t        r_q [DEPTH];
  logic [3:0]       r_count;
  logic             r_live;     // low until the first edge after reset release

  iq_entry_t        w_q_nxt [DEPTH];
  iq_entry_t        w_enq_raw, w_enq_entry, w_sel_entry, w_issue_entry;
  logic [DEPTH-1:0] w_valid, w_ready, w_grant;
  logic [3:0]       w_sel_idx, w_enq_idx, w_count_nxt;
  logic             w_any_ready, w_issue_q, w_enq_fire, w_enq_write, w_bypass;

  // Valid bits follow from the count because the queue never has holes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = (4'(i) < r_count);
      w_ready[i] = w_valid[i] & r_q[i].rs1_rdy & r_q[i].rs2_rdy;
    end
  end

  iq_oldest_select #(.N(DEPTH)) u_select (
    .i_req       (w_ready),
    .o_grant     (w_grant),
    .o_any_ready (w_any_ready)
  );

  // NOTE: every variable in a combinational block gets a default before any
  // conditional update, so no path holds a stale value and no latch appears.
  always_comb begin
    w_sel_idx   = '0;
    w_sel_entry = r_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_idx   = 4'(i);
        w_sel_entry = r_q[i];
      end
    end
  end

  assign w_enq_raw = '{sid: enq_sid_i, func3: enq_func3_i, auipc: enq_auipc_i,
                       pc: enq_pc_i, inst: enq_inst_i, func_code: enq_func_code_i,
                       rs1_rdy: enq_rs1_rdy_i, rs1_tag: enq_rs1_tag_i,
                       rs1_value: enq_rs1_value_i,
                       rs2_rdy: enq_rs2_rdy_i, rs2_tag: enq_rs2_tag_i,
                       rs2_value: enq_rs2_value_i};
  assign w_enq_entry = iq_wakeup(w_enq_raw, wb_valid_i, wb_sid_i, wb_value_i);

  // An issue this cycle frees a slot only at the next edge, so it does not
  // open enq_ready_o early.
  assign enq_ready_o = r_live & (r_count < DEPTH_C) & ~flush_i;
  assign w_enq_fire  = enq_valid_i & enq_ready_o;
  assign w_issue_q   = w_any_ready & ~flush_i;

`ifdef ALU_IQ_BYPASS_EN
  assign w_bypass = w_enq_fire & ~w_any_ready & w_enq_entry.rs1_rdy & w_enq_entry.rs2_rdy;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq_write = w_enq_fire & ~w_bypass;
  assign w_enq_idx   = r_count - {3'b000, w_issue_q};
  assign w_count_nxt = flush_i ? 4'd0
                               : r_count + {3'b000, w_enq_write} - {3'b000, w_issue_q};

  // NOTE: blocking '=' here lets each statement build on the previous one
  // (shift, then wakeup, then enqueue overwrite); registers use '<='.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int j;
      j = (i < DEPTH - 1) ? i + 1 : i;
      w_q_nxt[i] = r_q[i];
      if (w_issue_q && (4'(i) >= w_sel_idx)) begin
        w_q_nxt[i] = r_q[j];
      end
      w_q_nxt[i] = iq_wakeup(w_q_nxt[i], wb_valid_i, wb_sid_i, wb_value_i);
      if (w_enq_write && (4'(i) == w_enq_idx)) begin
        w_q_nxt[i] = w_enq_entry;
      end
    end
  end

  // NOTE: only control state (count and operand ready bits) is reset; the
  // payload is never observed before it is written, so it carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_live  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i].rs1_rdy <= 1'b0;
        r_q[i].rs2_rdy <= 1'b0;
      end
    end else begin
      r_live  <= 1'b1;
      r_count <= w_count_nxt;
      if (!flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_q[i] <= w_q_nxt[i];
        end
      end
    end
  end

  assign w_issue_entry = w_issue_q ? w_sel_entry : w_enq_entry;

  assign alu_valid_o = w_issue_q | w_bypass;
  assign alu_sid_o   = w_issue_entry.sid;
  assign alu_func3_o = w_issue_entry.func3;
  assign alu_auipc_o = w_issue_entry.auipc;
  assign alu_pc_o    = w_issue_entry.pc;
  assign alu_inst_o  = w_issue_entry.inst;
  assign rs1_value_o = w_issue_entry.rs1_value;
  assign rs2_value_o = w_issue_entry.rs2_value;
  assign func_code_o = w_issue_entry.func_code;
  assign count_o     = r_count;

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4; number of queue entries; legal values 2..8.
REQ-002 Parameter SID_W, default `SCOREBOARD_SIZE_WIDTH; scoreboard id and tag width.
REQ-003 Clock clk and reset rst_n SHALL be: reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  in  1  clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush_i  in  1  discard all entries.
REQ-007 enq_valid_i / enq_ready_o  in/out  1/1  enqueue handshake.
REQ-008 enq_sid_i, enq_func3_i, enq_auipc_i, enq_pc_i, enq_inst_i, enq_func_code_i  in  SID_W/3/1/64/32/4  op payload.
REQ-009 enq_rsN_rdy_i, enq_rsN_tag_i, enq_rsN_value_i (N=1,2)  in  1/SID_W/64  operand state.
REQ-010 wb_valid_i, wb_sid_i, wb_value_i  in  1/SID_W/64  result wakeup broadcast.
REQ-011 alu_valid_o, alu_sid_o, alu_func3_o, alu_auipc_o, alu_pc_o, alu_inst_o, rs1_value_o, rs2_value_o, func_code_o  out  1/SID_W/3/1/64/32/64/64/4  issue port to ALU.
REQ-012 count_o  out  4  occupied entries.

Function
REQ-013 Queue SHALL collapse: entry 0 is always the oldest, and occupied entries are contiguous from 0.
REQ-014 An entry SHALL be ready when both rsN_rdy bits are set; selection SHALL pick the lowest-index ready entry.
REQ-015 Issue SHALL use registered ready bits; at most one issue per cycle; the ALU port has no backpressure.
REQ-016 Issue port outputs SHALL be combinational from the selected entry; alu_valid_o=0 when there is no ready entry or flush_i=1.
REQ-017 On issue, entries above the selected index SHALL shift down by one at the next edge.
REQ-018 enq_ready_o SHALL be (count_o<DEPTH) & ~flush_i; issue in the same cycle SHALL NOT raise enq_ready_o.
REQ-019 On enqueue, the entry SHALL be written at index count_o, or at count_o-1 when an issue occurs in the same cycle.
REQ-020 Wakeup: each occupied entry with rsN_rdy=0 and rsN_tag==wb_sid_i while wb_valid_i=1 SHALL set rsN_rdy and capture wb_value_i.
REQ-021 Wakeup SHALL also apply to the op being enqueued in the same cycle.
REQ-022 A woken entry SHALL become issuable no earlier than the next cycle.
REQ-023 count_o SHALL update as +1 on enqueue, -1 on issue, and be unchanged when both occur.
REQ-024 flush_i SHALL clear all valid bits at the next edge; flush has priority over enqueue, wakeup and issue.

Reset
REQ-025 Reset SHALL clear all entry valid bits and rdy bits and set count_o=0; payload registers SHALL NOT be reset.
REQ-026 During reset: alu_valid_o=0, enq_ready_o=0; enq_ready_o=1 from the first edge after deassertion.

Configuration
REQ-027 With ALU_IQ_BYPASS_EN defined, a bypass issue SHALL occur when the queue has no ready entry and an accepted enqueue has both operands ready (including via same-cycle wakeup).
REQ-028 A bypass issue SHALL drive the op to the issue port in the same cycle, and the op SHALL NOT be written into the queue.
REQ-029 Without ALU_IQ_BYPASS_EN, the minimum enqueue-to-issue latency SHALL be 1 cycle and all ops SHALL pass through an entry.

Structure
REQ-030 Package alu_iq_pkg SHALL hold the entry struct typedef (payload, rdy bits, tags, values) and the DEPTH_MAX=8 constant.
REQ-031 Sub-module iq_oldest_select SHALL be a DEPTH-wide lowest-index priority selector producing a one-hot grant and an any_ready output.

Verification
REQ-032 Enqueue sid=3 with both operands ready, no bypass -> alu_valid_o=1 with alu_sid_o=3 one cycle later; count_o returns to 0.
REQ-033 Enqueue A (rs1 waiting on tag 5), then B (ready) -> B issues first; wb sid=5 value 0xABCD -> A issues the next cycle with rs1_value_o=0xABCD.
REQ-034 Fill 4 entries, none ready -> enq_ready_o=0; wake entry 1 -> it issues, entries 2 and 3 shift to 1 and 2, enq_ready_o=1.
REQ-035 Full queue with flush_i and enq_valid_i asserted together -> no enqueue, alu_valid_o=0, count_o=0 next cycle.
REQ-036 ALU_IQ_BYPASS_EN, empty queue, ready op sid=7 -> alu_valid_o=1 with sid 7 in the same cycle and count_o stays 0.
REQ-037 Enqueue with rs2 tag 9 while wb sid=9 in the same cycle -> captured value issues the next cycle.
